regfile_dump: RTL

- Debug read-out engine for the 64-bit architectural register file.
- Drives the register file's debug read port (address out, data in).
- On a start pulse, walks every register index in order and serializes each word into bytes on a valid/ready byte stream (feeds the debug UART TX).
- Sits beside the register file in the core top; purely a reader, never writes.

---
 rtl/regfile_dump.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
// Debug read-out engine for the architectural register file. A start pulse
// makes the block walk every register index in order. It snapshots each word
// through the debug read port and streams the word out as bytes, most
// significant byte first, on a valid/ready byte interface. The block only
// reads the register file and never writes it.
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra byte
// after the last register. That byte is the XOR of every dumped byte.
//
// Ports:
//   clk      - system clock, all state changes on posedge
//   reset_n  - asynchronous active-low reset
//   start    - dump request, only honoured while idle
//   ra_db    - debug read address to the register file (registered)
//   rd_db    - debug read data from the register file (async read of ra_db)
//   tx_data  - byte presented to the sink
//   tx_valid - tx_data is valid
//   tx_ready - sink accepts the byte on tx_valid && tx_ready
//   busy     - dump in progress
//   done     - one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int BANK_WIDTH = 5,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [BANK_WIDTH-1:0] ra_db,
    input  logic [WIDTH-1:0]      rd_db,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int WORDS = 2 ** BANK_WIDTH;
    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam logic [BANK_WIDTH-1:0] LAST_IDX  = BANK_WIDTH'(WORDS - 1);
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);

    generate
        if ((WIDTH % 8) != 0) begin : g_width_check
            $error("regfile_dump: WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_SEND  = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_FIN   = 3'd4
    } state_t;

    state_t                state_r,    state_s;
    logic [BANK_WIDTH-1:0] index_r,    index_s;
    logic [CNT_W-1:0]      byte_cnt_r, byte_cnt_s;
    logic [WIDTH-1:0]      shift_r,    shift_s;
    logic [WIDTH-1:0]      shifted_s;
    logic [BANK_WIDTH-1:0] ra_s;
    logic [7:0]            tx_data_s;
    logic                  tx_valid_s;
    logic                  busy_s;
    logic                  done_s;
    logic                  accept_s;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [7:0]            csum_r, csum_s;
`endif

    assign accept_s  = tx_valid && tx_ready;
    // The byte following the one on the wire is the top byte after the shift.
    assign shifted_s = shift_r << 4'd8;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        byte_cnt_s = byte_cnt_r;
        shift_s    = shift_r;
        ra_s       = ra_db;
        tx_data_s  = tx_data;
        tx_valid_s = tx_valid;
        busy_s     = busy;
        done_s     = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_s     = csum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LATCH;
                    index_s = {BANK_WIDTH{1'b0}};
                    ra_s    = {BANK_WIDTH{1'b0}};
                    busy_s  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_s  = 8'h00;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                // Snapshot the addressed word; its top byte goes out first.
                shift_s    = rd_db;
                byte_cnt_s = {CNT_W{1'b0}};
                tx_data_s  = rd_db[WIDTH-1 -: 8];
                tx_valid_s = 1'b1;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (accept_s) begin
                    shift_s   = shifted_s;
                    tx_data_s = shifted_s[WIDTH-1 -: 8];
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_s    = csum_r ^ tx_data;
`endif
                    if (byte_cnt_r == LAST_BYTE) begin
                        if (index_r == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // The checksum byte must include the byte just accepted.
                            tx_data_s  = csum_r ^ tx_data;
                            state_s    = ST_CSUM;
`else
                            tx_valid_s = 1'b0;
                            busy_s     = 1'b0;
                            done_s     = 1'b1;
                            ra_s       = {BANK_WIDTH{1'b0}};
                            state_s    = ST_FIN;
`endif
                        end else begin
                            index_s    = index_r + BANK_WIDTH'(1'b1);
                            ra_s       = index_r + BANK_WIDTH'(1'b1);
                            tx_valid_s = 1'b0;
                            state_s    = ST_LATCH;
                        end
                    end else begin
                        byte_cnt_s = byte_cnt_r + CNT_W'(1'b1);
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    tx_valid_s = 1'b0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    ra_s       = {BANK_WIDTH{1'b0}};
                    state_s    = ST_FIN;
                end else begin
                    state_s = ST_CSUM;
                end
            end
`endif
            ST_FIN: begin
                // done drops here through its default; start is not looked at.
                state_s = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
                ra_s       = {BANK_WIDTH{1'b0}};
            end
        endcase
    end

    // State and registered-output update, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            index_r    <= {BANK_WIDTH{1'b0}};
            byte_cnt_r <= {CNT_W{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            ra_db      <= {BANK_WIDTH{1'b0}};
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            index_r    <= index_s;
            byte_cnt_r <= byte_cnt_s;
            shift_r    <= shift_s;
            ra_db      <= ra_s;
            tx_data    <= tx_data_s;
            tx_valid   <= tx_valid_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // XOR accumulator over every accepted data byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_r <= 8'h00;
        end else begin
            csum_r <= csum_s;
        end
    end
`endif

endmodule
